// File: rtl/bp_me_wormhole_lce_req_tx.sv
// LCE-request wormhole transmitter.
// Round-robin arbitrates among num_src_p request sources. It builds the packet
// {data, hdr, cid, len, cord} and shifts it out LSB-first as flit_width_p-bit flits.
// A new packet can be loaded in the same cycle that the previous packet's last flit
// transfers, so back-to-back packets leave with no idle cycle between them.
module bp_me_wormhole_lce_req_tx #(
  parameter int num_src_p    = 2,
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 5,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 2,
  parameter int hdr_width_p  = 53,
  parameter int data_width_p = 512
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_src_p-1:0]                v_i,
  output logic [num_src_p-1:0]                yumi_o,
  input  logic [num_src_p*hdr_width_p-1:0]    hdr_i,
  input  logic [num_src_p*data_width_p-1:0]   data_i,
  input  logic [num_src_p-1:0]                has_data_i,
  input  logic [num_src_p*3-1:0]              size_i,
  input  logic [num_src_p*cord_width_p-1:0]   cord_i,
  input  logic [num_src_p*cid_width_p-1:0]    cid_i,
  output logic [flit_width_p-1:0]             flit_o,
  output logic                                v_o,
  input  logic                                ready_i,
  output logic                                last_o
);

  localparam int pkt_hdr_w = cord_width_p + len_width_p + cid_width_p + hdr_width_p;
  localparam int pkt_w     = pkt_hdr_w + data_width_p;
  localparam int max_flits = (pkt_w + flit_width_p - 1) / flit_width_p;
  localparam int img_w     = max_flits * flit_width_p;
  localparam int ptr_w     = (num_src_p > 1) ? $clog2(num_src_p) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [img_w-1:0]        shift_q, shift_d;
  logic [len_width_p-1:0]  cnt_q, cnt_d;
  logic [ptr_w-1:0]        ptr_q, ptr_d;

  logic                    can_load;
  logic                    grant_v;
  logic [ptr_w-1:0]        grant_idx;
  logic [num_src_p-1:0]    yumi;
  int                      arb_idx;

  logic [hdr_width_p-1:0]  sel_hdr;
  logic [data_width_p-1:0] sel_data, sel_data_m;
  logic                    sel_has_data;
  logic [2:0]              sel_size;
  logic [cord_width_p-1:0] sel_cord;
  logic [cid_width_p-1:0]  sel_cid;
  logic [len_width_p-1:0]  sel_len;
  int                      data_bits;
  int                      nflit;
  logic [img_w-1:0]        image;

  // Round-robin grant. The search starts at ptr_q, which is the source after the last one granted.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    yumi      = '0;
    arb_idx   = 0;
    can_load  = (state_q == IDLE) || (ready_i && (cnt_q == '0));
    for (int i = 0; i < num_src_p; i++) begin
      arb_idx = int'(ptr_q) + i;
      if (arb_idx >= num_src_p) arb_idx = arb_idx - num_src_p;
      if (!grant_v && v_i[arb_idx]) begin
        grant_v   = 1'b1;
        grant_idx = ptr_w'(arb_idx);
      end
    end
    if (can_load && grant_v) yumi[grant_idx] = 1'b1;
  end

  // Select the granted source. Compute its length and mask its data to form the packet image.
  always_comb begin
    sel_hdr      = hdr_i[int'(grant_idx)*hdr_width_p +: hdr_width_p];
    sel_data     = data_i[int'(grant_idx)*data_width_p +: data_width_p];
    sel_has_data = has_data_i[grant_idx];
    sel_size     = size_i[int'(grant_idx)*3 +: 3];
    sel_cord     = cord_i[int'(grant_idx)*cord_width_p +: cord_width_p];
    sel_cid      = cid_i[int'(grant_idx)*cid_width_p +: cid_width_p];
    data_bits    = 0;
    if (sel_has_data) begin
      data_bits = 8 << sel_size;
      if (data_bits > data_width_p) data_bits = data_width_p;
    end
    nflit   = (pkt_hdr_w + data_bits + flit_width_p - 1) / flit_width_p;
    sel_len = len_width_p'(nflit - 1);
    for (int j = 0; j < data_width_p; j++) begin
      sel_data_m[j] = sel_data[j] & (j < data_bits);
    end
    image             = '0;
    image[pkt_w-1:0]  = {sel_data_m, sel_hdr, sel_cid, sel_len, sel_cord};
  end

  // Next state: shift on each transfer and reload on a grant, which takes priority over returning to IDLE.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if ((state_q == SEND) && ready_i) begin
      if (cnt_q != '0) begin
        shift_d = shift_q >> flit_width_p;
        cnt_d   = cnt_q - len_width_p'(1);
      end else begin
        state_d = IDLE;
        shift_d = '0;
      end
    end
    if (can_load && grant_v) begin
      state_d = SEND;
      shift_d = image;
      cnt_d   = sel_len;
      if (int'(grant_idx) == num_src_p - 1) ptr_d = '0;
      else                                  ptr_d = ptr_w'(int'(grant_idx) + 1);
    end
  end

  // State registers. Reset discards any packet in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign yumi_o = yumi;
  assign v_o    = (state_q == SEND);
  assign last_o = (state_q == SEND) && (cnt_q == '0);
  assign flit_o = shift_q[flit_width_p-1:0];

endmodule

// File: tb/tb_bp_me_wormhole_lce_req_tx.sv
// Directed testbench for bp_me_wormhole_lce_req_tx.
module tb_bp_me_wormhole_lce_req_tx;

  localparam int NS = 2;
  localparam int FW = 64;
  localparam int CW = 5;
  localparam int LW = 4;
  localparam int IW = 2;
  localparam int HW = 53;
  localparam int DW = 512;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [NS-1:0]     v_i;
  logic [NS-1:0]     yumi_o;
  logic [NS*HW-1:0]  hdr_i;
  logic [NS*DW-1:0]  data_i;
  logic [NS-1:0]     has_data_i;
  logic [NS*3-1:0]   size_i;
  logic [NS*CW-1:0]  cord_i;
  logic [NS*IW-1:0]  cid_i;
  logic [FW-1:0]     flit_o;
  logic              v_o;
  logic              ready_i;
  logic              last_o;

  int vecs = 0;
  int miss = 0;

  logic [63:0]   exp_f [0:8];
  logic [63:0]   hf [0:1];
  logic [DW-1:0] dpat;
  logic [DW-1:0] dtmp;

  localparam logic [HW-1:0] H0 = 53'h0_1234_5678_9ABC;
  localparam logic [HW-1:0] H1 = 53'h1_EDCB_A987_6543;

  bp_me_wormhole_lce_req_tx #(
    .num_src_p(NS), .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW),
    .cid_width_p(IW), .hdr_width_p(HW), .data_width_p(DW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .yumi_o(yumi_o),
    .hdr_i(hdr_i), .data_i(data_i), .has_data_i(has_data_i), .size_i(size_i),
    .cord_i(cord_i), .cid_i(cid_i), .flit_o(flit_o), .v_o(v_o),
    .ready_i(ready_i), .last_o(last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_src(input int s, input logic [HW-1:0] h, input logic [DW-1:0] d,
                         input logic hd, input logic [2:0] sz,
                         input logic [CW-1:0] c, input logic [IW-1:0] id);
    hdr_i[s*HW +: HW]   = h;
    data_i[s*DW +: DW]  = d;
    has_data_i[s]       = hd;
    size_i[s*3 +: 3]    = sz;
    cord_i[s*CW +: CW]  = c;
    cid_i[s*IW +: IW]   = id;
  endtask

  // Raise the given valids, check the grant, let the load edge pass, then drop the valids.
  task automatic start_pkt(input logic [NS-1:0] vmask, input logic [NS-1:0] exp_yumi);
    v_i = vmask;
    #1;
    chk("yumi_load", 64'(yumi_o), 64'(exp_yumi));
    step();
    v_i = '0;
  endtask

  // Walk a packet of n flits against exp_f. When toggle is set, ready alternates 1,0,1,0,...
  task automatic drain(input int n, input bit toggle);
    int f;
    int cyc;
    f = 0;
    cyc = 0;
    while (f < n && cyc < 40) begin
      ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("v_o_send", 64'(v_o), 64'd1);
      chk("flit_o", flit_o, exp_f[f]);
      chk("last_o", 64'(last_o), 64'(f == n - 1));
      if (ready_i) f++;
      cyc++;
      step();
    end
    ready_i = 1'b1;
    chk("drain_done", 64'(f), 64'(n));
    #1;
    chk("v_o_idle", 64'(v_o), 64'd0);
  endtask

  initial begin
    reset_n_i  = 1'b0;
    v_i        = '0;
    hdr_i      = '0;
    data_i     = '0;
    has_data_i = '0;
    size_i     = '0;
    cord_i     = '0;
    cid_i      = '0;
    ready_i    = 1'b1;
    for (int k = 0; k < 8; k++) dpat[k*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(k + 1);

    // Reset values
    #12;
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_last_o", 64'(last_o), 64'd0);
    chk("rst_yumi_o", 64'(yumi_o), 64'd0);
    chk("rst_flit_o", flit_o, 64'd0);
    reset_n_i = 1'b1;
    step();

    // Header-only packet from source 0; an invalid size is ignored because there is no data
    set_src(0, H0, '0, 1'b0, 3'd7, 5'd3, 2'd1);
    exp_f[0] = {H0, 2'd1, 4'd0, 5'd3};
    start_pkt(2'b01, 2'b01);
    drain(1, 1'b0);

    // 8-byte write from source 1: header flit then the data flit
    dtmp = '0;
    dtmp[63:0]   = 64'hDEADBEEF_01234567;
    dtmp[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
    set_src(1, H1, dtmp, 1'b1, 3'd3, 5'd7, 2'd2);
    exp_f[0] = {H1, 2'd2, 4'd1, 5'd7};
    exp_f[1] = 64'hDEADBEEF_01234567;
    start_pkt(2'b10, 2'b10);
    drain(2, 1'b0);

    // Both sources valid with 1-flit packets: grants alternate with no bubble
    set_src(0, H0, '0, 1'b0, 3'd5, 5'd3, 2'd1);
    set_src(1, H1, '0, 1'b0, 3'd0, 5'd7, 2'd2);
    hf[0] = {H0, 2'd1, 4'd0, 5'd3};
    hf[1] = {H1, 2'd2, 4'd0, 5'd7};
    v_i = 2'b11;
    #1;
    chk("rr_yumi0", 64'(yumi_o), 64'(2'b01));
    for (int n = 1; n <= 4; n++) begin
      step();
      #1;
      chk("rr_v_o", 64'(v_o), 64'd1);
      chk("rr_flit", flit_o, hf[(n - 1) % 2]);
      chk("rr_last", 64'(last_o), 64'd1);
      chk("rr_yumi", 64'(yumi_o), (n % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
    end
    step();
    v_i = '0;
    #1;
    chk("rr_tail_flit", flit_o, hf[0]);
    chk("rr_tail_yumi", 64'(yumi_o), 64'd0);
    step();
    #1;
    chk("rr_end_v_o", 64'(v_o), 64'd0);

    // 64-byte write with ready toggling: 9 flits in order, held while ready is low
    set_src(0, H0, dpat, 1'b1, 3'd6, 5'd3, 2'd1);
    exp_f[0] = {H0, 2'd1, 4'd8, 5'd3};
    for (int k = 0; k < 8; k++) exp_f[k + 1] = dpat[k*64 +: 64];
    start_pkt(2'b01, 2'b01);
    drain(9, 1'b1);

    // size=7 is clamped to the full 512 data bits
    set_src(1, H1, dpat, 1'b1, 3'd7, 5'd7, 2'd2);
    exp_f[0] = {H1, 2'd2, 4'd8, 5'd7};
    start_pkt(2'b10, 2'b10);
    drain(9, 1'b0);

    // size=0 keeps byte 0 only; everything above it is sent as zero
    dtmp = dpat;
    dtmp[63:0] = 64'hDEADBEEF_01234567;
    set_src(0, H0, dtmp, 1'b1, 3'd0, 5'd3, 2'd1);
    exp_f[0] = {H0, 2'd1, 4'd1, 5'd3};
    exp_f[1] = 64'h0000_0000_0000_0067;
    start_pkt(2'b01, 2'b01);
    drain(2, 1'b0);

    // Reset asserted while flit 3 of 9 is presented
    set_src(0, H0, dpat, 1'b1, 3'd6, 5'd3, 2'd1);
    exp_f[0] = {H0, 2'd1, 4'd8, 5'd3};
    for (int k = 0; k < 8; k++) exp_f[k + 1] = dpat[k*64 +: 64];
    start_pkt(2'b01, 2'b01);
    for (int f = 0; f < 3; f++) begin
      ready_i = 1'b1;
      #1;
      chk("pre_rst_flit", flit_o, exp_f[f]);
      step();
    end
    #1;
    chk("pre_rst_flit3", flit_o, exp_f[3]);
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_v_o", 64'(v_o), 64'd0);
    chk("mid_rst_last_o", 64'(last_o), 64'd0);
    chk("mid_rst_flit_o", flit_o, 64'd0);
    step();
    reset_n_i = 1'b1;
    #1;
    chk("post_rst_v_o", 64'(v_o), 64'd0);
    set_src(0, H1, '0, 1'b0, 3'd2, 5'd9, 2'd3);
    exp_f[0] = {H1, 2'd3, 4'd0, 5'd9};
    start_pkt(2'b01, 2'b01);
    drain(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
